cache_init_ctrl: RTL and testbench
==================================

Name: cache_init_ctrl

Overview:
- Per-bank sequencer that generates the tag-store `init` stream: walks every line index of the bank, asserting `init` plus the line index.
- Runs once after reset and again on each flush request.
- Sits directly upstream of the bank's tag store, muxed ahead of normal lookups. Holds `busy` so the bank core rejects requests until the walk completes.

Parameters:
- CACHE_SIZE, 1024, cache size in bytes
- LINE_SIZE, 16, line size in bytes
- NUM_BANKS, 1, number of banks
- NUM_WAYS, 1, associative ways
- INIT_ON_RESET, 1, 1 = perform a full walk after reset; 0 = come out of reset in IDLE

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush_valid  in  1  flush request
- flush_ready  out  1  flush request accepted this cycle when flush_valid && flush_ready
- pipe_empty  in  1  bank pipeline and MSHR hold no in-flight requests
- stall  in  1  bank pipeline stall; the sequencer freezes
- init  out  1  drives tag-store init for the current index
- init_line_sel  out  LINE_SEL_BITS  line index being initialised
- busy  out  1  bank must not accept core requests
- done_valid  out  1  one-cycle flush-completion pulse
- done_ready  in  1  completion consumer ready

Behaviour:
- Constants:
  - LINES_PER_BANK = CACHE_SIZE / (LINE_SIZE × NUM_BANKS × NUM_WAYS).
  - LINE_SEL_BITS = max(1, clog2(LINES_PER_BANK)).
- States: IDLE, DRAIN, INIT, DONE.
- Reset (async, active-high): counter = 0; done_valid = 0; flush_ready = 0.
  - INIT_ON_RESET = 1: state = INIT, init = 1, busy = 1.
  - INIT_ON_RESET = 0: state = IDLE, init = 0, busy = 0.
- IDLE:
  - busy = 0, init = 0, flush_ready = 1.
  - flush_valid → DRAIN next cycle.
- DRAIN:
  - busy = 1, flush_ready = 0.
  - Waits for pipe_empty = 1; enters INIT with counter = 0 on the cycle after pipe_empty is sampled high.
- INIT:
  - busy = 1; init = 1 while ~stall; init_line_sel = counter.
  - Counter increments by 1 on each cycle with ~stall. On stall, counter and init_line_sel hold and init = 0, so no write is issued.
  - When counter == LINES_PER_BANK−1 and ~stall:
    - flush-initiated walk → DONE;
    - reset-initiated walk → IDLE, with no done pulse.
  - Counter never wraps inside a walk.
  - Walk latency = LINES_PER_BANK unstalled cycles.
- DONE:
  - busy = 1, done_valid = 1.
  - Holds until done_ready; then IDLE on the next cycle.
- Simultaneous events:
  - A flush_valid arriving during INIT, DRAIN or DONE is not accepted (flush_ready = 0); the requester holds it.
  - stall and the last index in the same cycle: completion is deferred.
- Reset mid-walk: immediately restarts per INIT_ON_RESET; any pending flush is dropped and the requester re-issues it.
- Outputs are registered except init, which is state==INIT && ~stall.

Optional Feature:
- Macro: CS_INIT_PERF_EN.
- Defined:
  - adds output perf_flush_cycles (32 bits), counting cycles spent in DRAIN+INIT+DONE across all flushes;
  - saturates at 0xFFFFFFFF; cleared by reset.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared cache package holds:
  - LINES_PER_BANK / LINE_SEL_BITS computations, reused by the tag and data stores;
  - the state enum typedef (IDLE/DRAIN/INIT/DONE).
- One natural sub-module: cache_init_counter, a stall-gated up-counter with terminal-count flag.
- FSM stays in the top.

Test Plan:
- Reset release, defaults (64 lines), stall = 0 → init high for exactly 64 cycles with init_line_sel 0..63, then busy = 0 and no done_valid.
- IDLE, flush_valid = 1, pipe_empty = 0 for 5 cycles then 1 → no init during drain; 64 init cycles; done_valid held until done_ready = 1, then IDLE.
- stall asserted for 3 cycles at init_line_sel = 10 → init = 0 and index held at 10; resumes at 10; total walk 67 cycles.
- flush_valid asserted during a reset-initiated walk → flush_ready = 0 until IDLE; accepted on the first IDLE cycle.
- Async reset pulse at init_line_sel = 40 mid-flush → outputs reset immediately; new walk starts at 0; no done pulse.
- CS_INIT_PERF_EN defined, flush with 5 drain + 64 init + 2 done cycles → perf_flush_cycles = 71.

Source files
------------

// File: rtl/cache_init_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_init_ctrl_pkg
// Shared cache definitions:
//   - line-count and line-select-width helpers. The tag and data stores use
//     the same helpers, so every block agrees on the bank geometry.
//   - the init-sequencer state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cache_init_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      INIT  = 2'd2,
      DONE  = 2'd3
   } init_state_e;

   localparam int PERF_W = 32;

   // Lines held by one way of one bank.
   function automatic int calc_lines_per_bank(input int cache_size,
                                              input int line_size,
                                              input int num_banks,
                                              input int num_ways);
      return cache_size / (line_size * num_banks * num_ways);
   endfunction

   // Index width. This is at least one bit, so a single-line bank still has a
   // legal select port.
   function automatic int calc_line_sel_bits(input int lines);
      return (lines > 1) ? $clog2(lines) : 1;
   endfunction

endpackage

// File: rtl/cache_init_counter.sv
// -----------------------------------------------------------------------------
// cache_init_counter
// Stall-gated up-counter for the tag-store init walk. It stops at LAST and does
// not wrap. o_tc flags the terminal index.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   i_clear     synchronous clear to 0 (takes priority over i_en)
//   i_en        advance by one (ignored at terminal count)
//   o_count     current index
//   o_tc        current index == LAST
// -----------------------------------------------------------------------------
module cache_init_counter #(
   parameter int WIDTH = 6,
   parameter int LAST  = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en && !o_tc) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == LAST_VAL);

endmodule

// File: rtl/cache_init_ctrl.sv
// -----------------------------------------------------------------------------
// cache_init_ctrl
// Per-bank tag-store init sequencer. It walks every line index, asserting init
// with the index. It runs once after reset (when INIT_ON_RESET=1) and again on
// each accepted flush. While it is busy, the bank core rejects requests.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   flush_valid/ready  flush request handshake (ready only in IDLE)
//   pipe_empty         bank pipeline and MSHR are empty; ends DRAIN
//   stall              freezes the walk; no init write that cycle
//   init               tag-store init strobe (combinational: INIT && ~stall)
//   init_line_sel      line index being initialised
//   busy               bank must not accept core requests
//   done_valid/ready   completion handshake for flush-initiated walks
//   perf_flush_cycles  (only with CS_INIT_PERF_EN) saturating count of
//                      DRAIN+INIT+DONE cycles across flushes
// Optional feature macro: CS_INIT_PERF_EN
// -----------------------------------------------------------------------------
module cache_init_ctrl
   import cache_init_ctrl_pkg::*;
#(
   parameter  int CACHE_SIZE     = 1024,
   parameter  int LINE_SIZE      = 16,
   parameter  int NUM_BANKS      = 1,
   parameter  int NUM_WAYS       = 1,
   parameter  int INIT_ON_RESET  = 1,
   localparam int LINES_PER_BANK = calc_lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
   localparam int LINE_SEL_BITS  = calc_line_sel_bits(LINES_PER_BANK)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_valid,
   output logic                     flush_ready,
   input  logic                     pipe_empty,
   input  logic                     stall,
   output logic                     init,
   output logic [LINE_SEL_BITS-1:0] init_line_sel,
   output logic                     busy,
   output logic                     done_valid,
   input  logic                     done_ready
`ifdef CS_INIT_PERF_EN
   ,
   output logic [PERF_W-1:0]        perf_flush_cycles
`endif
);

   localparam init_state_e RESET_STATE = (INIT_ON_RESET != 0) ? INIT : IDLE;

   init_state_e              r_state, w_next_state;
   logic                     r_flush_walk;   // current walk came from a flush
   logic                     r_busy, r_flush_ready, r_done_valid;
   logic                     w_ctr_clear, w_ctr_en, w_ctr_tc;
   logic [LINE_SEL_BITS-1:0] w_ctr_count;

   cache_init_counter #(
      .WIDTH (LINE_SEL_BITS),
      .LAST  (LINES_PER_BANK - 1)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_ctr_clear),
      .i_en    (w_ctr_en),
      .o_count (w_ctr_count),
      .o_tc    (w_ctr_tc)
   );

   // The registered outputs are loaded from the next state, so each one is
   // valid in the same cycle as the state it describes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= RESET_STATE;
         r_flush_walk  <= 1'b0;
         r_busy        <= (INIT_ON_RESET != 0);
         r_flush_ready <= 1'b0;
         r_done_valid  <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_busy        <= (w_next_state != IDLE);
         r_flush_ready <= (w_next_state == IDLE);
         r_done_valid  <= (w_next_state == DONE);
         if (r_state == IDLE && w_next_state == DRAIN) begin
            r_flush_walk <= 1'b1;
         end
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ctr_clear  = 1'b1;   // index sits at 0 outside INIT, so each walk starts at 0
      w_ctr_en     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (flush_valid && r_flush_ready) w_next_state = DRAIN;
         end
         DRAIN: begin
            if (pipe_empty) w_next_state = INIT;
         end
         INIT: begin
            w_ctr_clear = 1'b0;
            if (!stall) begin
               w_ctr_en = 1'b1;
               // Completion is gated by ~stall, so a stalled last index defers it.
               if (w_ctr_tc) w_next_state = r_flush_walk ? DONE : IDLE;
            end
         end
         DONE: begin
            if (done_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign init          = (r_state == INIT) && !stall;
   assign init_line_sel = w_ctr_count;
   assign busy          = r_busy;
   assign flush_ready   = r_flush_ready;
   assign done_valid    = r_done_valid;

`ifdef CS_INIT_PERF_EN
   logic [PERF_W-1:0] r_perf;

   // Only flush walks are counted; the reset walk leaves r_flush_walk clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf <= '0;
      end else if (r_state != IDLE && r_flush_walk && r_perf != '1) begin
         r_perf <= r_perf + 1'b1;
      end
   end

   assign perf_flush_cycles = r_perf;
`endif

endmodule

// File: tb/tb_cache_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_init_ctrl
// Bench for cache_init_ctrl at its default geometry (64 lines).
// The reference model tracks the bank as a mode (idle / drain / walk / done),
// the index being written, and whether the walk came from a flush. Directed
// scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_cache_init_ctrl;

   localparam int LINES  = 1024 / 16;
   localparam int M_IDLE = 0;
   localparam int M_DRAIN = 1;
   localparam int M_WALK = 2;
   localparam int M_DONE = 3;

   logic       clk, reset;
   logic       flush_valid, flush_ready, pipe_empty, stall;
   logic       init, busy, done_valid, done_ready;
   logic [5:0] init_line_sel;
`ifdef CS_INIT_PERF_EN
   logic [31:0] perf_flush_cycles;
`endif

   cache_init_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .flush_valid   (flush_valid),
      .flush_ready   (flush_ready),
      .pipe_empty    (pipe_empty),
      .stall         (stall),
      .init          (init),
      .init_line_sel (init_line_sel),
      .busy          (busy),
      .done_valid    (done_valid),
      .done_ready    (done_ready)
`ifdef CS_INIT_PERF_EN
      ,
      .perf_flush_cycles (perf_flush_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   int          m_mode;
   int          m_idx;
   bit          m_from_flush;
   bit          m_ready;
   longint      m_perf;

   // Observation counters used by the directed scenarios.
   int n_init, n_done, n_walk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode       = M_WALK;
      m_idx        = 0;
      m_from_flush = 1'b0;
      m_ready      = 1'b0;
      m_perf       = 0;
   endtask

   // Advance the model by one clock, using the inputs that were held across the edge.
   task automatic model_step(input bit fv, input bit pe, input bit st, input bit dr);
      if (m_mode != M_IDLE && m_from_flush && m_perf < 64'hFFFF_FFFF) m_perf++;
      case (m_mode)
         M_IDLE:  if (fv && m_ready) begin m_mode = M_DRAIN; m_from_flush = 1'b1; end
         M_DRAIN: if (pe) begin m_mode = M_WALK; m_idx = 0; end
         M_WALK:  if (!st) begin
                     if (m_idx == LINES - 1) m_mode = m_from_flush ? M_DONE : M_IDLE;
                     else m_idx++;
                  end
         default: if (dr) m_mode = M_IDLE;
      endcase
      m_ready = (m_mode == M_IDLE);
   endtask

   task automatic check_regs();
      check("busy", busy, m_mode != M_IDLE);
      check("flush_ready", flush_ready, m_ready);
      check("done_valid", done_valid, m_mode == M_DONE);
`ifdef CS_INIT_PERF_EN
      check("perf", perf_flush_cycles, m_perf[31:0]);
`endif
   endtask

   // One clock cycle. Inputs are applied at posedge+1, the combinational init
   // is checked at posedge+2, and the registered outputs at the next posedge+1.
   task automatic cycle(input bit fv, input bit pe, input bit st, input bit dr);
      flush_valid = fv; pipe_empty = pe; stall = st; done_ready = dr;
      #1;
      check("init", init, (m_mode == M_WALK) && !st);
      if (m_mode == M_WALK) begin
         check("line_sel", init_line_sel, m_idx);
         n_walk++;
      end
      if (init) n_init++;
      if (done_valid) n_done++;
      @(posedge clk);
      #1;
      model_step(fv, pe, st, dr);
      check_regs();
   endtask

   // Asynchronous reset, asserted away from the clock edge; the outputs must react at once.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_busy", busy, 1);
      check("rst_ready", flush_ready, 0);
      check("rst_done", done_valid, 0);
      check("rst_sel", init_line_sel, 0);
      check("rst_init", init, !stall);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_regs();
   endtask

   task automatic clr_counts();
      n_init = 0; n_done = 0; n_walk = 0;
   endtask

   // Finish whatever is in flight; the cycle budget bounds it.
   task automatic run_to_idle(input string tag);
      int i;
      for (i = 0; i < 400 && m_mode != M_IDLE; i++) cycle(0, 1, 0, 1);
      check({tag, "_reached_idle"}, busy, 0);
   endtask

   initial begin
      reset = 1'b0; flush_valid = 1'b0; pipe_empty = 1'b0; stall = 1'b0; done_ready = 1'b0;
      #2;

      // 1: the reset walk takes 64 init cycles and gives no done pulse.
      do_reset();
      clr_counts();
      for (int i = 0; i < 200 && m_mode != M_IDLE; i++) cycle(0, 1, 0, 0);
      check("t1_busy_after", busy, 0);
      check("t1_init_cycles", n_init, LINES);
      check("t1_done_pulses", n_done, 0);

      // 2: flush with 5 drain cycles, 64 init cycles, and done held for 2 cycles.
      clr_counts();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      check("t2_no_init_in_drain", n_init, 0);
      for (int i = 0; i < 200 && m_mode != M_DONE; i++) cycle(0, 1, 0, 0);
      check("t2_init_cycles", n_init, LINES);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 1);
      check("t2_idle_after_ack", busy, 0);
      check("t2_done_cycles", n_done, 2);
`ifdef CS_INIT_PERF_EN
      check("t2_perf_71", perf_flush_cycles, 71);
`endif

      // 3: a 3-cycle stall at index 10 makes the walk 67 cycles long.
      begin
         int stall_left;
         stall_left = 3;
         clr_counts();
         cycle(1, 0, 0, 0);
         cycle(0, 1, 0, 0);
         for (int i = 0; i < 200 && m_mode == M_WALK; i++) begin
            if (m_idx == 10 && stall_left > 0) begin
               stall_left--;
               cycle(0, 1, 1, 1);
            end else begin
               cycle(0, 1, 0, 1);
            end
         end
         check("t3_walk_cycles", n_walk, LINES + 3);
         check("t3_init_cycles", n_init, LINES);
         run_to_idle("t3");
      end

      // 4: a flush held during the reset walk is accepted on the first IDLE cycle.
      do_reset();
      for (int i = 0; i < 200 && m_mode != M_IDLE; i++) cycle(1, 1, 0, 0);
      check("t4_ready_in_idle", flush_ready, 1);
      cycle(1, 0, 0, 0);
      check("t4_accepted", busy, 1);
      run_to_idle("t4");

      // 5: an async reset at index 40 of a flush walk restarts at 0 and gives no done pulse.
      cycle(1, 1, 0, 0);
      for (int i = 0; i < 200 && !(m_mode == M_WALK && m_idx == 40); i++) cycle(0, 1, 0, 0);
      check("t5_at_40", init_line_sel, 40);
      do_reset();
      clr_counts();
      for (int i = 0; i < 200 && m_mode != M_IDLE; i++) cycle(0, 1, 0, 1);
      check("t5_init_cycles", n_init, LINES);
      check("t5_done_pulses", n_done, 0);

      // 6: randomized traffic against the model, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit fv, pe, st, dr;
         fv = ($urandom_range(0, 3) == 0);
         pe = ($urandom_range(0, 2) != 0);
         st = (m_mode == M_WALK) ? ($urandom_range(0, 4) == 0) : 1'b0;
         dr = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle(fv, pe, st, dr);
      end
      run_to_idle("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
